imm_gen_stage: RTL and testbench

Registered, parametrised immediate-generation stage for the decode pipeline. It accepts one 32-bit instruction per cycle over a valid/ready handshake and returns the XLEN-wide immediate, a format code and an illegal flag, all one cycle later. It adds RV64 support (XLEN=64 with 6-bit shamt and OP-IMM-32), illegal-encoding detection, a skid buffer for full throughput under backpressure, and a flush input. It sits between the fetch/decode boundary and the register-read stage.

---
 rtl/imm_gen_stage_pkg.sv | 35 +++
 rtl/imm_decode_comb.sv | 99 +++++++++
 rtl/imm_gen_stage.sv | 122 ++++++++++++
 tb/tb_imm_gen_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_stage_pkg.sv
// Shared opcode, funct3 and immediate-format encodings for the immediate-generation stage.
package imm_gen_stage_pkg;

  localparam logic [6:0] INST_TYPE_LOAD      = 7'b0000011;
  localparam logic [6:0] INST_TYPE_OP_IMM    = 7'b0010011;
  localparam logic [6:0] INST_TYPE_AUIPC     = 7'b0010111;
  localparam logic [6:0] INST_TYPE_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] INST_TYPE_STORE     = 7'b0100011;
  localparam logic [6:0] INST_TYPE_OP        = 7'b0110011;
  localparam logic [6:0] INST_TYPE_LUI       = 7'b0110111;
  localparam logic [6:0] INST_TYPE_OP_32     = 7'b0111011;
  localparam logic [6:0] INST_TYPE_BRANCH    = 7'b1100011;
  localparam logic [6:0] INST_TYPE_JALR      = 7'b1100111;
  localparam logic [6:0] INST_TYPE_JAL       = 7'b1101111;
  localparam logic [6:0] INST_TYPE_SYSTEM    = 7'b1110011;

  localparam logic [2:0] INST_SLL = 3'b001;
  localparam logic [2:0] INST_SR  = 3'b101;

  typedef enum logic [2:0] {
    FmtR     = 3'd0,
    FmtI     = 3'd1,
    FmtS     = 3'd2,
    FmtB     = 3'd3,
    FmtU     = 3'd4,
    FmtJ     = 3'd5,
    FmtShamt = 3'd6,
    FmtNone  = 3'd7
  } fmt_e;

  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == INST_SLL) || (funct3 == INST_SR);
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational instruction -> {immediate, format, illegal} decoder, XLEN-parameterised.
module imm_decode_comb
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          RV64_W = 1'b1
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  localparam bit Is64 = (XLEN == 64);
  localparam bit HasW = Is64 && RV64_W;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic signed [11:0] imm_i_s;
  logic signed [11:0] imm_s_s;
  logic signed [12:0] imm_b_s;
  logic signed [31:0] imm_u_s;
  logic signed [20:0] imm_j_s;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign imm_i_s = instr_i[31:20];
  assign imm_s_s = {instr_i[31:25], instr_i[11:7]};
  assign imm_b_s = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u_s = {instr_i[31:12], 12'b0};
  assign imm_j_s = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // Size casts of signed operands sign-extend from instr[31] up to XLEN.
  always_comb begin
    imm_o     = '0;
    fmt_o     = FmtNone;
    illegal_o = 1'b0;
    case (opcode)
      INST_TYPE_OP: fmt_o = FmtR;
      INST_TYPE_OP_32: begin
        if (HasW) fmt_o = FmtR;
        else      illegal_o = 1'b1;
      end
      INST_TYPE_LOAD, INST_TYPE_JALR: begin
        imm_o = XLEN'(imm_i_s);
        fmt_o = FmtI;
      end
      INST_TYPE_OP_IMM: begin
        if (is_shift(funct3)) begin
          fmt_o = FmtShamt;
          if (Is64) begin
            imm_o = XLEN'(instr_i[25:20]);
          end else begin
            imm_o     = XLEN'(instr_i[24:20]);
            illegal_o = instr_i[25];
          end
        end else begin
          imm_o = XLEN'(imm_i_s);
          fmt_o = FmtI;
        end
      end
      INST_TYPE_OP_IMM_32: begin
        if (!HasW) begin
          illegal_o = 1'b1;
        end else if (is_shift(funct3)) begin
          imm_o     = XLEN'(instr_i[24:20]);
          fmt_o     = FmtShamt;
          illegal_o = instr_i[25];
        end else begin
          imm_o = XLEN'(imm_i_s);
          fmt_o = FmtI;
        end
      end
      INST_TYPE_SYSTEM: begin
        // CSR address is an unsigned index.
        imm_o = XLEN'(instr_i[31:20]);
        fmt_o = FmtI;
      end
      INST_TYPE_STORE: begin
        imm_o = XLEN'(imm_s_s);
        fmt_o = FmtS;
      end
      INST_TYPE_BRANCH: begin
        imm_o = XLEN'(imm_b_s);
        fmt_o = FmtB;
      end
      INST_TYPE_LUI, INST_TYPE_AUIPC: begin
        imm_o = XLEN'(imm_u_s);
        fmt_o = FmtU;
      end
      INST_TYPE_JAL: begin
        imm_o = XLEN'(imm_j_s);
        fmt_o = FmtJ;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decoder followed by an output register and a skid
// register so the stage sustains one instruction per cycle under backpressure.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          RV64_W = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  imm_decode_comb #(
    .XLEN   (XLEN),
    .RV64_W (RV64_W)
  ) u_decode (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [2:0]      out_fmt_q, out_fmt_d;
  logic            out_ill_q, out_ill_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [2:0]      skid_fmt_q, skid_fmt_d;
  logic            skid_ill_q, skid_ill_d;
  logic            ready_q, ready_d;
  logic            accept;
  logic            consume;

  assign accept  = in_valid & ready_q;
  assign consume = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    if (flush) begin
      // Any beat accepted this cycle is discarded along with the held entries.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || consume) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_ill_d    = skid_ill_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_fmt_d   = dec_fmt;
        out_ill_d   = dec_illegal;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_ill_d   = dec_illegal;
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FmtNone;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FmtNone;
      skid_ill_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus and are checked
// against a scoreboard queue plus an arithmetic immediate model.
module tb_imm_gen_stage;

  localparam longint P32 = 64'sh1_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'd0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;

  imm_gen_stage #(.XLEN(32), .RV64_W(1'b1)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready32),
    .in_instr    (in_instr),
    .out_valid   (out_valid32),
    .out_ready   (out_ready),
    .out_imm     (out_imm32),
    .out_fmt     (out_fmt32),
    .out_illegal (out_illegal32)
  );

  imm_gen_stage #(.XLEN(64), .RV64_W(1'b1)) dut64 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready64),
    .in_instr    (in_instr),
    .out_valid   (out_valid64),
    .out_ready   (out_ready),
    .out_imm     (out_imm64),
    .out_fmt     (out_fmt64),
    .out_illegal (out_illegal64)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;
  bit          armed = 1'b0;
  logic [31:0] q[$];

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint fld(input logic [31:0] ins, input int lo, input int w);
    return longint'((ins >> lo) & ((32'd1 << w) - 32'd1));
  endfunction

  // Immediate value computed arithmetically from the field layout of each format.
  function automatic exp_t model(input logic [31:0] ins, input int xlen);
    exp_t   e;
    longint v;
    longint top;
    logic [6:0] opc;
    logic [2:0] f3;
    opc   = ins[6:0];
    f3    = ins[14:12];
    top   = ins[31] ? -64'sd1 : 64'sd0;
    v     = 0;
    e.imm = '0;
    e.fmt = 3'd7;
    e.ill = 1'b0;
    case (opc)
      7'h33: e.fmt = 3'd0;
      7'h3B: if (xlen == 64) e.fmt = 3'd0; else e.ill = 1'b1;
      7'h03, 7'h67: begin v = top * 4096 + fld(ins, 20, 12); e.fmt = 3'd1; end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.fmt = 3'd6;
          if (xlen == 64) v = fld(ins, 20, 6);
          else begin v = fld(ins, 20, 5); e.ill = ins[25]; end
        end else begin
          v = top * 4096 + fld(ins, 20, 12); e.fmt = 3'd1;
        end
      end
      7'h1B: begin
        if (xlen != 64) e.ill = 1'b1;
        else if (f3 == 3'd1 || f3 == 3'd5) begin
          v = fld(ins, 20, 5); e.fmt = 3'd6; e.ill = ins[25];
        end else begin
          v = top * 4096 + fld(ins, 20, 12); e.fmt = 3'd1;
        end
      end
      7'h73: begin v = fld(ins, 20, 12); e.fmt = 3'd1; end
      7'h23: begin v = top * 4096 + fld(ins, 25, 7) * 32 + fld(ins, 7, 5); e.fmt = 3'd2; end
      7'h63: begin
        v = top * 8192 + fld(ins, 31, 1) * 4096 + fld(ins, 7, 1) * 2048
            + fld(ins, 25, 6) * 32 + fld(ins, 8, 4) * 2;
        e.fmt = 3'd3;
      end
      7'h37, 7'h17: begin v = top * P32 + fld(ins, 12, 20) * 4096; e.fmt = 3'd4; end
      7'h6F: begin
        v = top * 2097152 + fld(ins, 31, 1) * 1048576 + fld(ins, 12, 8) * 4096
            + fld(ins, 20, 1) * 2048 + fld(ins, 21, 10) * 2;
        e.fmt = 3'd5;
      end
      default: e.ill = 1'b1;
    endcase
    if (xlen == 32) e.imm = {32'd0, v[31:0]};
    else            e.imm = v;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) armed <= 1'b0;
    else     armed <= 1'b1;
  end

  // Per-cycle compare against the scoreboard; then advance it for the coming edge.
  always @(negedge clk) begin
    exp_t e32, e64;
    bit   exp_rdy;
    if (rst) begin
      chk("rst_valid32", 64'(out_valid32), 64'(1'b0));
      chk("rst_valid64", 64'(out_valid64), 64'(1'b0));
      chk("rst_fmt32", 64'(out_fmt32), 64'(3'd7));
      chk("rst_imm64", out_imm64, 64'd0);
      chk("rst_ready32", 64'(in_ready32), 64'(1'b0));
      q.delete();
    end else begin
      exp_rdy = armed && (q.size() < 2);
      chk("in_ready32", 64'(in_ready32), 64'(exp_rdy));
      chk("in_ready64", 64'(in_ready64), 64'(exp_rdy));
      chk("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
      chk("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
      if (q.size() != 0) begin
        e32 = model(q[0], 32);
        e64 = model(q[0], 64);
        chk("imm32", {32'd0, out_imm32}, e32.imm);
        chk("fmt32", 64'(out_fmt32), 64'(e32.fmt));
        chk("ill32", 64'(out_illegal32), 64'(e32.ill));
        chk("imm64", out_imm64, e64.imm);
        chk("fmt64", 64'(out_fmt64), 64'(e64.fmt));
        chk("ill64", 64'(out_illegal64), 64'(e64.ill));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) begin
          void'(q.pop_front());
          n_pop++;
        end
        if (in_valid && exp_rdy) q.push_back(in_instr);
      end
    end
  end

  task automatic send(input logic [31:0] ins);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready32) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0, want 1 within 50 cycles");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100us");
    n_err++;
    summary();
    $fatal(1);
  end

  vec_t vecs[16];
  exp_t m;
  int   pop0;

  initial begin
    vecs = '{
      '{32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0},
      '{32'hFE000EE3, 64'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0},
      '{32'h800002B7, 64'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0},
      '{32'h02109093, 64'h1,        3'd6, 1'b1, 64'h21,               3'd6, 1'b0},
      '{32'h0000007F, 64'h0,        3'd7, 1'b1, 64'h0,                3'd7, 1'b1},
      '{32'hC0002573, 64'hC00,      3'd1, 1'b0, 64'hC00,              3'd1, 1'b0},
      '{32'hFFF0809B, 64'h0,        3'd7, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0},
      '{32'h0210909B, 64'h0,        3'd7, 1'b1, 64'h1,                3'd6, 1'b1},
      '{32'h4050D093, 64'h5,        3'd6, 1'b0, 64'h5,                3'd6, 1'b0},
      '{32'h002081B3, 64'h0,        3'd0, 1'b0, 64'h0,                3'd0, 1'b0},
      '{32'h002081BB, 64'h0,        3'd7, 1'b1, 64'h0,                3'd0, 1'b0},
      '{32'hFE112E23, 64'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0},
      '{32'h0080006F, 64'h8,        3'd5, 1'b0, 64'h8,                3'd5, 1'b0},
      '{32'hFFDFF0EF, 64'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0},
      '{32'h00001097, 64'h1000,     3'd4, 1'b0, 64'h1000,             3'd4, 1'b0},
      '{32'h00812083, 64'h8,        3'd1, 1'b0, 64'h8,                3'd1, 1'b0}
    };

    // Asynchronous reset, observed before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid32", 64'(out_valid32), 64'(1'b0));
    chk("async_rst_fmt64", 64'(out_fmt64), 64'(3'd7));
    chk("async_rst_ill32", 64'(out_illegal32), 64'(1'b0));
    chk("async_rst_ready64", 64'(in_ready64), 64'(1'b0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed single-beat vectors with literal expectations on model and DUT.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      m = model(vecs[i].ins, 32);
      chk($sformatf("model32_imm_%0h", vecs[i].ins), m.imm, vecs[i].imm32);
      chk($sformatf("model32_fmt_%0h", vecs[i].ins), 64'(m.fmt), 64'(vecs[i].fmt32));
      chk($sformatf("model32_ill_%0h", vecs[i].ins), 64'(m.ill), 64'(vecs[i].ill32));
      m = model(vecs[i].ins, 64);
      chk($sformatf("model64_imm_%0h", vecs[i].ins), m.imm, vecs[i].imm64);
      chk($sformatf("model64_fmt_%0h", vecs[i].ins), 64'(m.fmt), 64'(vecs[i].fmt64));
      chk($sformatf("model64_ill_%0h", vecs[i].ins), 64'(m.ill), 64'(vecs[i].ill64));
      send(vecs[i].ins);
      @(negedge clk);
      chk($sformatf("lat1_valid_%0h", vecs[i].ins), 64'(out_valid32 & out_valid64), 64'(1'b1));
      chk($sformatf("dut32_imm_%0h", vecs[i].ins), {32'd0, out_imm32}, vecs[i].imm32);
      chk($sformatf("dut32_fmt_%0h", vecs[i].ins), 64'(out_fmt32), 64'(vecs[i].fmt32));
      chk($sformatf("dut32_ill_%0h", vecs[i].ins), 64'(out_illegal32), 64'(vecs[i].ill32));
      chk($sformatf("dut64_imm_%0h", vecs[i].ins), out_imm64, vecs[i].imm64);
      chk($sformatf("dut64_fmt_%0h", vecs[i].ins), 64'(out_fmt64), 64'(vecs[i].fmt64));
      chk($sformatf("dut64_ill_%0h", vecs[i].ins), 64'(out_illegal64), 64'(vecs[i].ill64));
    end

    // Backpressure: four back-to-back beats while the consumer stalls for three cycles.
    @(posedge clk);
    #1 pop0 = n_pop;
    fork
      begin
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        send(32'hFFF00093);
        send(32'hFE000EE3);
        send(32'h800002B7);
        send(32'h02109093);
      end
    join
    repeat (6) @(negedge clk);
    chk("bp_beats_out", 64'(n_pop - pop0), 64'd4);

    // Flush with output and skid both full; the beat offered alongside is not accepted.
    @(posedge clk);
    #1 out_ready = 1'b0;
    pop0 = n_pop;
    send(32'h0080006F);
    send(32'h00001097);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hFE112E23;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_full_valid", 64'(out_valid32 | out_valid64), 64'(1'b0));
    chk("flush_full_ready", 64'(in_ready32), 64'(1'b1));
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("flush_full_no_beat", 64'(n_pop - pop0), 64'd0);

    // Flush in the same cycle a beat is accepted: the accepted beat is dropped.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h4050D093);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hC0002573;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_acc_valid", 64'(out_valid64), 64'(1'b0));
    chk("flush_acc_ready", 64'(in_ready64), 64'(1'b1));
    repeat (2) @(negedge clk);
    chk("flush_acc_no_beat", 64'(n_pop - pop0), 64'd0);

    // Asynchronous reset mid-stream with both entries occupied.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h0000007F);
    send(32'hFFDFF0EF);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid32", 64'(out_valid32), 64'(1'b0));
    chk("midrst_imm64", out_imm64, 64'd0);
    chk("midrst_fmt32", 64'(out_fmt32), 64'(3'd7));
    chk("midrst_ill64", 64'(out_illegal64), 64'(1'b0));
    chk("midrst_ready32", 64'(in_ready32), 64'(1'b0));
    @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    send(32'hFFF00093);
    @(negedge clk);
    chk("postrst_lat1_valid", 64'(out_valid32), 64'(1'b1));
    chk("postrst_imm32", {32'd0, out_imm32}, 64'hFFFFFFFF);
    chk("postrst_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);
    chk("postrst_no_ghost", 64'(out_valid64), 64'(1'b0));

    summary();
    $finish;
  end

endmodule
